// File: rtl/pe_alu_pkg.sv
// Shared definitions for the PE ALU arbiter: opcodes, FSM states and an
// opcode legality helper.
package pe_alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUX = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR = 3'd3;
  localparam logic [OP_W-1:0] OP_MUL = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes above OP_OR (6 and 7) are unassigned.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// searching upward from ptr with wrap-around. Outputs a one-hot grant and
// the encoded index of the winner; both are zero when nothing requests.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest active request
  // (lowest offset from ptr) is the last to write and therefore wins.
  always_comb begin
    int c;
    // NOTE: every output of a combinational block gets a default before any
    // conditional write; otherwise a latch is inferred for the idle case.
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/pe_alu_arbiter.sv
// One shared PE ALU serving N_REQ requesters, one operation in flight.
// Round-robin grant in IDLE, single-cycle execute for all ops except MUL
// (MUL_LAT cycles), then a held response until the consumer accepts it.
module pe_alu_arbiter
  import pe_alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                   UserCLK,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [OP_W*N_REQ-1:0]  req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]       req_s,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int CNT_W = 3;

  state_e             r_state;
  logic [ID_W-1:0]    r_prio_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_s;
  logic [ID_W-1:0]    r_id;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_err;

  logic [N_REQ-1:0]   w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_accept;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_alu_data;
  logic               w_alu_err;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_prio_ptr),
    .gnt (w_gnt),
    .idx (w_gnt_idx)
  );

  // Grants are offered only while idle; outside IDLE no requester is accepted.
  assign req_ready  = (r_state == ST_IDLE) ? w_gnt : '0;
  assign w_accept   = |req_ready;
  assign w_next_ptr = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_mul_done = (r_cnt == CNT_W'(MUL_LAT - 1));

  // ALU evaluation on the latched operands; illegal codes give zero + error.
  always_comb begin
    w_alu_data = '0;
    w_alu_err  = 1'b0;
    case (r_op)
      OP_ADD:  w_alu_data = r_a + r_b;
      OP_SUB:  w_alu_data = r_a - r_b;
      OP_MUX:  w_alu_data = r_s ? r_b : r_a;
      OP_XOR:  w_alu_data = r_a ^ r_b;
      OP_MUL:  w_alu_data = r_a * r_b;
      OP_OR:   w_alu_data = r_a | r_b;
      default: w_alu_err  = ~op_legal(r_op);
    endcase
  end

  // Control FSM with registered response; reset discards any in-flight op.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_prio_ptr  <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= req_op[OP_W*w_gnt_idx +: OP_W];
            r_a        <= req_a[WIDTH*w_gnt_idx +: WIDTH];
            r_b        <= req_b[WIDTH*w_gnt_idx +: WIDTH];
            r_s        <= req_s[w_gnt_idx];
            r_id       <= w_gnt_idx;
            r_prio_ptr <= w_next_ptr;
            r_cnt      <= '0;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_op == OP_MUL && !w_mul_done) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_rsp_data  <= w_alu_data;
            r_rsp_err   <= w_alu_err;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/pe_alu_arbiter.md
Name: pe_alu_arbiter

Overview:
- Shares one PE ALU (add, sub, mux, xor, mul, or) among N_REQ requesters, with one operation in flight at a time.
- Round-robin arbitration.
- valid/ready handshake on each request channel; a single shared response channel carries the requester ID.
- Multiplication is multi-cycle (MUL_LAT cycles); all other operations complete in one execute cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width in bits.
- MUL_LAT, 2, execute cycles for MUL (1..4).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- UserCLK  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_op  in  3*N_REQ  opcode per requester (slice i = bits [3i+2:3i]).
- req_a  in  WIDTH*N_REQ  operand A per requester.
- req_b  in  WIDTH*N_REQ  operand B per requester.
- req_s  in  N_REQ  mux select per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- rsp_data  out  WIDTH  result.
- rsp_err  out  1  opcode was illegal.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Opcodes (3 bits): ADD=0, SUB=1, MUX=2, XOR=3, MUL=4, OR=5. Codes 6 and 7 are illegal.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - SUB = A-B, wrapping (0-1 = all ones).
  - MUL = low WIDTH bits of A*B.
  - MUX = S ? B : A.
  - Illegal opcode: rsp_data=0, rsp_err=1.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is one-hot, pointing at the first requester with req_valid=1, searching from prio_ptr upward with wrap-around. req_ready is 0 when no request is valid.
  - req_ready is combinational from req_valid and prio_ptr, and is zero outside IDLE.
  - On accept: latch op, A, B, S and ID; set prio_ptr = (granted index + 1) mod N_REQ; go to EXEC with cnt=0.
- EXEC:
  - Non-MUL ops and illegal ops: result is registered at the end of this single cycle; next state is RESP.
  - MUL: cnt increments each cycle; the result is registered and the state moves to RESP when cnt == MUL_LAT-1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready, go to IDLE. A new grant can occur in the cycle after the response handshake, not in the same cycle.
- Latency, counting accept at edge t:
  - Non-MUL: rsp_valid is high after edge t+1.
  - MUL: rsp_valid is high after edge t+MUL_LAT.
  - Throughput (non-MUL, rsp_ready tied 1): one operation per 3 cycles.
- Requester rules:
  - A requester must hold req_valid and its operands stable until req_ready.
  - Dropping req_valid before a grant is permitted; no grant is issued for that requester.
- Simultaneous requests: only one grant per cycle. Losers keep req_valid and are served in later rounds. No requester waits more than N_REQ-1 other grants.
- Reset, asynchronous and at any time, including mid-EXEC or mid-RESP:
  - State=IDLE, prio_ptr=0, cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - The in-flight operation is discarded with no response.
- Operand registers are captured only on accept; the external A/B/S inputs are ignored outside IDLE.

Decomposition:
- Shared package pe_alu_pkg holds:
  - opcode localparams OP_ADD..OP_OR;
  - OP_W=3;
  - a function `op_legal(op)`.
- Sub-module rr_arbiter (N parameter):
  - inputs: request vector, pointer;
  - output: one-hot grant plus encoded index;
  - purely combinational.
- The ALU function evaluation is inline in pe_alu_arbiter.

Test Plan:
1. Single ADD: requester 2 issues op=0, A=0x0000_0005, B=0x0000_0007, rsp_ready=1. Required: req_ready[2] in the same cycle; rsp_valid one cycle after accept with rsp_id=2, rsp_data=0x0000_000C, rsp_err=0.
2. MUL latency and wrap (MUL_LAT=2): requester 0 issues MUL with A=0x0001_0000, B=0x0001_0000. Required: rsp_valid 2 cycles after accept, rsp_data=0x0000_0000; A=3, B=0xFFFF_FFFF gives 0xFFFF_FFFD.
3. Round-robin: all 4 requesters hold valid with SUB, A=i, B=1, rsp_ready=1. Required: grant order 0,1,2,3,0. Requester 0's result is 0xFFFF_FFFF; requester 3's result is 2.
4. Backpressure: rsp_ready=0 for 5 cycles after an XOR with A=0xF0F0_F0F0, B=0xFFFF_0000. Required: rsp_valid held with rsp_data=0x0F0F_F0F0 stable, no req_ready asserted, busy=1; after rsp_ready=1 the state returns to IDLE.
5. MUX and illegal opcode:
   - MUX with S=1, A=0xAAAA_AAAA, B=0x5555_5555. Required: rsp_data=0x5555_5555.
   - op=7. Required: rsp_data=0, rsp_err=1.
6. Reset mid-MUL: assert resetn=0 while in EXEC. Required: rsp_valid=0 and busy=0 immediately (asynchronously). After release, requester 0 is granted first and no stale response appears.
